clk_ratio_monitor: RTL

Measures the period and high-phase length of a divided clock in units of `i_ref_clk` cycles. It checks each measurement against an expected integer ratio and reports lock, mismatch and timeout. It sits at the receive end of the clock-divider output: it reads the divided clock back in the reference domain so that firmware and the test bench can confirm the programmed division ratio and duty cycle. Only clocks derived synchronously from `i_ref_clk` are supported.

---
 rtl/clk_mon_pkg.sv | 12 +
 rtl/edge_sync.sv | 28 ++
 rtl/clk_ratio_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock ratio monitor.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      MEAS
   } mon_state_t;

   localparam int unsigned LOCK_CNT_DEFAULT = 4;

endpackage

// File: rtl/edge_sync.sv
// Three-flop sampler of the monitored clock with one-cycle rise/fall strobes.
module edge_sync (
   input  logic i_ref_clk,
   input  logic i_rst_n,
   input  logic i_mon_clk,
   output logic o_rise,
   output logic o_fall
);

   logic s1, s2, s3;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= i_mon_clk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign o_rise = s2 & ~s3;
   assign o_fall = ~s2 & s3;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high phase of a divided clock in reference cycles and
// checks them against an expected ratio, reporting lock, mismatch and timeout.
module clk_ratio_monitor
   import clk_mon_pkg::*;
#(
   parameter int RATIO_WIDTH = 8,
   parameter int LOCK_CNT    = LOCK_CNT_DEFAULT
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst_n,
   input  logic                   i_en,
   input  logic                   i_mon_clk,
   input  logic [RATIO_WIDTH-1:0] i_exp_ratio,
   output logic [RATIO_WIDTH-1:0] o_meas_ratio,
   output logic [RATIO_WIDTH-1:0] o_high_cnt,
   output logic                   o_meas_valid,
   output logic                   o_lock,
   output logic                   o_mismatch,
   output logic                   o_timeout
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [RATIO_WIDTH-1:0] PER_MAX = '1;
   localparam logic [RATIO_WIDTH-1:0] PER_ONE = RATIO_WIDTH'(1);
   localparam logic [RATIO_WIDTH-1:0] EXP_MIN = RATIO_WIDTH'(2);
   localparam logic [RATIO_WIDTH:0]   EXT_ONE = (RATIO_WIDTH + 1)'(1);
   localparam logic [MW-1:0]          LOCK_TGT = MW'(LOCK_CNT);
   localparam logic [MW-1:0]          MATCH_ONE = MW'(1);

   mon_state_t             state_q, state_d;
   logic                   rise, fall;
   logic [RATIO_WIDTH-1:0] per_cnt;
   logic [RATIO_WIDTH-1:0] high_q;
   logic [RATIO_WIDTH-1:0] meas_new;
   logic [RATIO_WIDTH:0]   meas_ext, twice_high;
   logic [MW-1:0]          match_cnt;
   logic                   timeout_hit, capture, duty_ok, good;

   edge_sync u_edge_sync (
      .i_ref_clk (i_ref_clk),
      .i_rst_n   (i_rst_n),
      .i_mon_clk (i_mon_clk),
      .o_rise    (rise),
      .o_fall    (fall)
   );

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      capture     = 1'b0;
      case (state_q)
         IDLE: if (i_en) state_d = SYNC;
         SYNC: begin
            if (per_cnt == PER_MAX) timeout_hit = 1'b1;
            else if (rise)          state_d     = MEAS;
         end
         MEAS: begin
            if (per_cnt == PER_MAX) begin
               timeout_hit = 1'b1;
               state_d     = SYNC;
            end else if (rise) begin
               capture = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!i_en) begin
         state_d     = IDLE;
         timeout_hit = 1'b0;
         capture     = 1'b0;
      end
   end

   // Duty check in one extra bit: 2*high must land within one of the period.
   assign meas_new   = per_cnt + PER_ONE;
   assign meas_ext   = {1'b0, meas_new};
   assign twice_high = {high_q, 1'b0};
   assign duty_ok    = (twice_high == meas_ext) ||
                       (twice_high == meas_ext + EXT_ONE) ||
                       (twice_high == meas_ext - EXT_ONE);
   assign good       = (meas_new == i_exp_ratio) && (i_exp_ratio >= EXP_MIN) && duty_ok;

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         per_cnt      <= '0;
         high_q       <= '0;
         match_cnt    <= '0;
         o_meas_ratio <= '0;
         o_high_cnt   <= '0;
         o_meas_valid <= 1'b0;
         o_mismatch   <= 1'b0;
         o_timeout    <= 1'b0;
      end else if (!i_en) begin
         per_cnt      <= '0;
         high_q       <= '0;
         match_cnt    <= '0;
         o_meas_ratio <= '0;
         o_high_cnt   <= '0;
         o_meas_valid <= 1'b0;
         o_mismatch   <= 1'b0;
         o_timeout    <= 1'b0;
      end else begin
         o_meas_valid <= 1'b0;
         o_mismatch   <= 1'b0;
         if (timeout_hit) begin
            o_timeout <= 1'b1;
            match_cnt <= '0;
            per_cnt   <= '0;
         end else if (capture) begin
            o_meas_ratio <= meas_new;
            o_high_cnt   <= high_q;
            o_meas_valid <= 1'b1;
            o_timeout    <= 1'b0;
            per_cnt      <= '0;
            if (good) begin
               if (match_cnt != LOCK_TGT) match_cnt <= match_cnt + MATCH_ONE;
            end else begin
               o_mismatch <= 1'b1;
               match_cnt  <= '0;
            end
         end else begin
            case (state_q)
               SYNC: per_cnt <= rise ? '0 : per_cnt + PER_ONE;
               MEAS: begin
                  per_cnt <= per_cnt + PER_ONE;
                  if (fall) high_q <= meas_new;
               end
               default: per_cnt <= '0;
            endcase
         end
      end
   end

   assign o_lock = (match_cnt == LOCK_TGT);

endmodule
